// File: rtl/com_bus_arbiter_rr.sv
// Round-robin arbiter for the shared common bus: one processor owner at a time,
// with snoop-side and memory-snoop grants sequenced while the owner holds the bus.
module com_bus_arbiter_rr #(
    parameter int unsigned NUM_PROC  = 8,
    parameter int unsigned NUM_SNOOP = 4,
    parameter int unsigned MAX_HOLD  = 0,
    parameter int unsigned PID_W     = $clog2(NUM_PROC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
    input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
    input  logic                 Mem_snoop_req,
    output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
    output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop,
    output logic                 Mem_snoop_gnt,
    output logic                 bus_busy,
    output logic [PID_W-1:0]     owner_id,
    output logic                 arb_timeout
);

    localparam int unsigned SID_W  = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;
    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(MAX_HOLD);
    localparam logic [PID_W-1:0]  PROC_LAST  = PID_W'(NUM_PROC - 1);
    localparam logic [SID_W-1:0]  SNOOP_LAST = SID_W'(NUM_SNOOP - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t               state, state_n;
    logic [PID_W-1:0]     proc_ptr, proc_ptr_n, owner_n, pick_p;
    logic [SID_W-1:0]     snoop_ptr, snoop_ptr_n, pick_s;
    logic [HOLD_W-1:0]    hold_cnt, hold_n;
    logic [NUM_PROC-1:0]  gnt_proc_n;
    logic [NUM_SNOOP-1:0] gnt_snoop_n;
    logic                 mem_gnt_n, timeout_n;

    // First requester above ptr, wrapping; index 0 follows the last index.
    function automatic logic [PID_W-1:0] rr_proc(input logic [NUM_PROC-1:0] req,
                                                 input logic [PID_W-1:0] ptr);
        logic [PID_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_PROC; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_PROC) idx = idx - NUM_PROC;
            if (!found && req[PID_W'(idx)]) begin
                pick  = PID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [SID_W-1:0] rr_snoop(input logic [NUM_SNOOP-1:0] req,
                                                  input logic [SID_W-1:0] ptr);
        logic [SID_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_SNOOP; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_SNOOP) idx = idx - NUM_SNOOP;
            if (!found && req[SID_W'(idx)]) begin
                pick  = SID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            proc_ptr          <= PROC_LAST;
            snoop_ptr         <= SNOOP_LAST;
            hold_cnt          <= '0;
            Com_Bus_Gnt_proc  <= '0;
            Com_Bus_Gnt_snoop <= '0;
            Mem_snoop_gnt     <= 1'b0;
            bus_busy          <= 1'b0;
            owner_id          <= '0;
            arb_timeout       <= 1'b0;
        end else begin
            state             <= state_n;
            proc_ptr          <= proc_ptr_n;
            snoop_ptr         <= snoop_ptr_n;
            hold_cnt          <= hold_n;
            Com_Bus_Gnt_proc  <= gnt_proc_n;
            Com_Bus_Gnt_snoop <= gnt_snoop_n;
            Mem_snoop_gnt     <= mem_gnt_n;
            bus_busy          <= |gnt_proc_n;
            owner_id          <= owner_n;
            arb_timeout       <= timeout_n;
        end
    end

    // Next-state, ownership and snoop sub-arbitration
    always_comb begin
        state_n     = state;
        proc_ptr_n  = proc_ptr;
        snoop_ptr_n = snoop_ptr;
        hold_n      = hold_cnt;
        owner_n     = owner_id;
        gnt_proc_n  = Com_Bus_Gnt_proc;
        gnt_snoop_n = Com_Bus_Gnt_snoop;
        mem_gnt_n   = Mem_snoop_gnt;
        timeout_n   = 1'b0;
        pick_p      = rr_proc(Com_Bus_Req_proc, proc_ptr);
        pick_s      = rr_snoop(Com_Bus_Req_snoop, snoop_ptr);

        case (state)
            IDLE: begin
                gnt_proc_n  = '0;
                gnt_snoop_n = '0;
                mem_gnt_n   = 1'b0;
                if (|Com_Bus_Req_proc) begin
                    gnt_proc_n[pick_p] = 1'b1;
                    owner_n            = pick_p;
                    proc_ptr_n         = pick_p;
                    hold_n             = '0;
                    state_n            = OWN;
                end
            end
            OWN: begin
                if (!Com_Bus_Req_proc[owner_id]) begin
                    gnt_proc_n  = '0;
                    gnt_snoop_n = '0;
                    mem_gnt_n   = 1'b0;
                    state_n     = IDLE;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
                    gnt_proc_n  = '0;
                    gnt_snoop_n = '0;
                    mem_gnt_n   = 1'b0;
                    timeout_n   = 1'b1;
                    state_n     = IDLE;
                end else begin
                    if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) hold_n = hold_cnt + HOLD_W'(1);
                    // A cleared snoop/mem grant leaves one idle cycle before the next
                    if (|Com_Bus_Gnt_snoop) begin
                        if (!(|(Com_Bus_Gnt_snoop & Com_Bus_Req_snoop))) gnt_snoop_n = '0;
                    end else if (Mem_snoop_gnt) begin
                        if (!Mem_snoop_req) mem_gnt_n = 1'b0;
                    end else if (|Com_Bus_Req_snoop) begin
                        gnt_snoop_n         = '0;
                        gnt_snoop_n[pick_s] = 1'b1;
                        snoop_ptr_n         = pick_s;
                    end else if (Mem_snoop_req) begin
                        mem_gnt_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_com_bus_arbiter_rr.sv
// Bench for com_bus_arbiter_rr: directed scenarios plus randomized traffic against
// a behavioural model, on an unlimited-hold instance (a) and a MAX_HOLD=4 instance (b).
module tb_com_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_proc;
    logic [3:0] req_snoop;
    logic       mem_req;

    logic [7:0] gp_a, gp_b;
    logic [3:0] gs_a, gs_b;
    logic       mg_a, mg_b, busy_a, busy_b, tmo_a, tmo_b;
    logic [2:0] oid_a, oid_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    com_bus_arbiter_rr #(.NUM_PROC(8), .NUM_SNOOP(4), .MAX_HOLD(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .Com_Bus_Req_proc(req_proc), .Com_Bus_Req_snoop(req_snoop), .Mem_snoop_req(mem_req),
        .Com_Bus_Gnt_proc(gp_a), .Com_Bus_Gnt_snoop(gs_a), .Mem_snoop_gnt(mg_a),
        .bus_busy(busy_a), .owner_id(oid_a), .arb_timeout(tmo_a)
    );

    com_bus_arbiter_rr #(.NUM_PROC(8), .NUM_SNOOP(4), .MAX_HOLD(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .Com_Bus_Req_proc(req_proc), .Com_Bus_Req_snoop(req_snoop), .Mem_snoop_req(mem_req),
        .Com_Bus_Gnt_proc(gp_b), .Com_Bus_Gnt_snoop(gs_b), .Mem_snoop_gnt(mg_b),
        .bus_busy(busy_b), .owner_id(oid_b), .arb_timeout(tmo_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_proc  = '0;
        req_snoop = '0;
        mem_req   = 1'b0;
        rst_n     = 1'b0;
        #2;
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        req_proc  = '0;
        req_snoop = '0;
        mem_req   = 1'b0;
        rst_n     = 1'b0;
        #1;
        n_checks++;
        if ({gp_a, gs_a, mg_a, busy_a, oid_a, tmo_a} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_a outputs got %h exp 0", {gp_a, gs_a, mg_a, busy_a, oid_a, tmo_a});
        end
        n_checks++;
        if ({gp_b, gs_b, mg_b, busy_b, oid_b, tmo_b} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_b outputs got %h exp 0", {gp_b, gs_b, mg_b, busy_b, oid_b, tmo_b});
        end
        #1 rst_n = 1'b1;
        req_proc = 8'h04;
        tick();
        n_checks++;
        if (gp_a !== 8'h04 || oid_a !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_pre_own gnt got %h owner %0d exp 04 owner 2", gp_a, oid_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (gp_a !== 8'h00 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_gnt gnt got %h busy %b exp 00 0", gp_a, busy_a);
        end
        n_checks++;
        if (oid_a !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_async_owner got %0d exp 0", oid_a);
        end
        req_proc = '0;
        rst_n    = 1'b1;
    endtask

    task automatic test_fairness();
        logic [7:0] exp;
        do_reset();
        req_proc = 8'hFF;
        tick();
        for (int n = 0; n < 9; n++) begin
            exp = 8'(32'd1 << (n % 8));
            n_checks++;
            if (gp_a !== exp || oid_a !== 3'(n % 8)) begin
                n_fail++;
                $display("FAIL fair_grant[%0d] gnt got %h owner %0d exp %h owner %0d", n, gp_a, oid_a, exp, n % 8);
            end
            tick();
            tick();
            n_checks++;
            if (gp_a !== exp) begin
                n_fail++;
                $display("FAIL fair_hold[%0d] gnt got %h exp %h", n, gp_a, exp);
            end
            req_proc = 8'hFF & ~exp;
            tick();
            n_checks++;
            if (gp_a !== 8'h00 || busy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL fair_gap[%0d] gnt got %h busy %b exp 00 0", n, gp_a, busy_a);
            end
            req_proc = 8'hFF;
            tick();
        end
        req_proc = '0;
        tick();
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_proc = 8'h81;
        tick();
        n_checks++;
        if (gp_a !== 8'h01) begin
            n_fail++;
            $display("FAIL simul_first gnt got %h exp 01", gp_a);
        end
        req_proc = 8'h80;
        tick();
        n_checks++;
        if (gp_a !== 8'h00) begin
            n_fail++;
            $display("FAIL simul_release gnt got %h exp 00", gp_a);
        end
        req_proc = 8'h81;
        tick();
        n_checks++;
        if (gp_a !== 8'h80 || oid_a !== 3'd7) begin
            n_fail++;
            $display("FAIL simul_second gnt got %h owner %0d exp 80 owner 7", gp_a, oid_a);
        end
        req_proc = '0;
        tick();
    endtask

    task automatic test_snoop_priority();
        logic [3:0] exp_s [7];
        logic       exp_m [7];
        logic [3:0] drv_s [7];
        logic       drv_m [7];
        // Per step: snoop/mem requests driven before the edge, expected grants after it
        drv_s = '{4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        drv_m = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b0};
        exp_s = '{4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        exp_m = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0};
        do_reset();
        req_proc = 8'h04;
        tick();
        for (int s = 0; s < 7; s++) begin
            req_snoop = drv_s[s];
            mem_req   = drv_m[s];
            tick();
            n_checks++;
            if (gs_a !== exp_s[s] || mg_a !== exp_m[s] || gp_a !== 8'h04) begin
                n_fail++;
                $display("FAIL snoop_seq[%0d] snoop %b mem %b proc %h exp %b %b 04",
                         s, gs_a, mg_a, gp_a, exp_s[s], exp_m[s]);
            end
        end
        req_proc = '0;
        tick();
        n_checks++;
        if (gp_a !== 8'h00) begin
            n_fail++;
            $display("FAIL snoop_release gnt got %h exp 00", gp_a);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_proc = 8'h20;
        tick();
        req_proc = 8'h21;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (gp_b !== 8'h20 || tmo_b !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_hold[%0d] gnt got %h tmo %b exp 20 0", c, gp_b, tmo_b);
            end
            if (c < 3) tick();
        end
        tick();
        n_checks++;
        if (gp_b !== 8'h00 || tmo_b !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_release gnt got %h tmo %b exp 00 1", gp_b, tmo_b);
        end
        tick();
        n_checks++;
        if (gp_b !== 8'h01 || tmo_b !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_next gnt got %h tmo %b exp 01 0", gp_b, tmo_b);
        end
        req_proc = '0;
        tick();
    endtask

    task automatic test_idle_isolation();
        do_reset();
        req_snoop = 4'hF;
        mem_req   = 1'b1;
        repeat (6) begin
            tick();
            n_checks++;
            if (gs_a !== 4'h0 || mg_a !== 1'b0 || gs_b !== 4'h0 || mg_b !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_iso snoop %b/%b mem %b/%b exp 0", gs_a, gs_b, mg_a, mg_b);
            end
        end
        req_snoop = '0;
        mem_req   = 1'b0;
    endtask

    task automatic test_random();
        int         own [2], last [2], pptr [2], sptr [2], sg [2], hold [2];
        bit         mg [2], tmo [2];
        logic [7:0] rp, agp, egp;
        logic [3:0] rs, ags, egs;
        logic       mr, amg, abusy, atmo;
        logic [2:0] aoid;
        int         mh;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = -1; last[k] = 0; pptr[k] = 7; sptr[k] = 3;
            sg[k] = -1; hold[k] = 0; mg[k] = 1'b0; tmo[k] = 1'b0;
        end
        rp = '0; rs = '0; mr = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rp ^= 8'($urandom() & $urandom() & $urandom());
            rs ^= 4'($urandom() & $urandom());
            if ($urandom_range(3) == 0) mr = ~mr;
            req_proc = rp; req_snoop = rs; mem_req = mr;
            for (int k = 0; k < 2; k++) begin
                mh     = (k == 0) ? 0 : 4;
                tmo[k] = 1'b0;
                if (own[k] < 0) begin
                    sg[k] = -1; mg[k] = 1'b0;
                    for (int i = 1; i <= 8; i++) begin
                        int c;
                        c = (pptr[k] + i) % 8;
                        if (rp[3'(c)]) begin
                            own[k] = c; last[k] = c; pptr[k] = c; hold[k] = 0;
                            break;
                        end
                    end
                end else if (!rp[3'(own[k])]) begin
                    own[k] = -1; sg[k] = -1; mg[k] = 1'b0;
                end else if (mh != 0 && hold[k] == mh - 1) begin
                    own[k] = -1; sg[k] = -1; mg[k] = 1'b0; tmo[k] = 1'b1;
                end else begin
                    if (hold[k] < mh) hold[k]++;
                    if (sg[k] >= 0) begin
                        if (!rs[2'(sg[k])]) sg[k] = -1;
                    end else if (mg[k]) begin
                        if (!mr) mg[k] = 1'b0;
                    end else if (rs != 0) begin
                        for (int i = 1; i <= 4; i++) begin
                            int c;
                            c = (sptr[k] + i) % 4;
                            if (rs[2'(c)]) begin
                                sg[k] = c; sptr[k] = c;
                                break;
                            end
                        end
                    end else if (mr) begin
                        mg[k] = 1'b1;
                    end
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                if (k == 0) {agp, ags, amg, abusy, aoid, atmo} = {gp_a, gs_a, mg_a, busy_a, oid_a, tmo_a};
                else        {agp, ags, amg, abusy, aoid, atmo} = {gp_b, gs_b, mg_b, busy_b, oid_b, tmo_b};
                egp = (own[k] >= 0) ? 8'(32'd1 << own[k]) : 8'h00;
                egs = (sg[k] >= 0) ? 4'(32'd1 << sg[k]) : 4'h0;
                n_checks++;
                if (agp !== egp || abusy !== (own[k] >= 0) || aoid !== 3'(last[k])) begin
                    n_fail++;
                    $display("FAIL rand_proc[%0d] cyc %0d gnt %h busy %b owner %0d exp %h %b %0d",
                             k, cyc, agp, abusy, aoid, egp, own[k] >= 0, last[k]);
                end
                n_checks++;
                if (ags !== egs || amg !== mg[k] || atmo !== tmo[k]) begin
                    n_fail++;
                    $display("FAIL rand_snoop[%0d] cyc %0d snoop %b mem %b tmo %b exp %b %b %b",
                             k, cyc, ags, amg, atmo, egs, mg[k], tmo[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_simultaneous();
        test_snoop_priority();
        test_timeout();
        test_idle_isolation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/com_bus_arbiter_rr.md
# com_bus_arbiter_rr

Parametrised round-robin arbiter for the shared common bus of the MESI multi-core cache system. It grants bus ownership to one processor-side cache at a time and sequences snoop-side grants from the other caches and the memory snoop port while that owner holds the bus. It adds three behaviours: configurable channel counts, fair rotating priority, and an optional hold-time limit that forces release. It sits between the cache wrappers and the memory model, alongside the system clock source.

## Interface
Parameters:
- NUM_PROC, 8, number of processor-side requesters (>= 2)
- NUM_SNOOP, 4, number of snoop-side requesters (>= 1)
- MAX_HOLD, 0, maximum processor ownership length in cycles; 0 = unlimited
- PID_W, $clog2(NUM_PROC), width of owner_id (derived)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Com_Bus_Req_proc  in  NUM_PROC  processor bus requests, level, held until transaction done
- Com_Bus_Req_snoop  in  NUM_SNOOP  snoop-side requests, level
- Mem_snoop_req  in  1  memory snoop request, level
- Com_Bus_Gnt_proc  out  NUM_PROC  one-hot-or-zero processor grant
- Com_Bus_Gnt_snoop  out  NUM_SNOOP  one-hot-or-zero snoop grant
- Mem_snoop_gnt  out  1  memory snoop grant
- bus_busy  out  1  high while any processor grant is active
- owner_id  out  PID_W  index of current/last processor owner
- arb_timeout  out  1  one-cycle pulse on forced release

## Operation
- Reset (asynchronous, immediate): all grants 0, bus_busy 0, arb_timeout 0, owner_id 0, state IDLE, proc pointer = NUM_PROC-1, snoop pointer = NUM_SNOOP-1. Index 0 is highest priority after reset.
- FSM states: IDLE, OWN.
- IDLE, any Com_Bus_Req_proc set:
  - Grant the first requester searching upward from pointer+1, wrapping modulo NUM_PROC.
  - Set owner_id, pointer := granted index, clear hold counter, go to OWN.
- IDLE, no request: stay; all grants 0.
- OWN, Req_proc[owner] deasserted: clear all proc, snoop and mem grants; go to IDLE.
- OWN, MAX_HOLD != 0 and hold counter == MAX_HOLD-1 with request still high:
  - Forced release: clear all grants, pulse arb_timeout, go to IDLE.
  - The pointer already points at the owner, so it becomes lowest priority next arbitration.
- Snoop sub-arbitration (OWN only; snoop and mem grants are always 0 in IDLE):
  - No snoop or mem grant active, Req_snoop nonzero: round-robin grant from snoop pointer+1; snoop pointer := granted index.
  - Active snoop grant held while its request stays high; cleared on the edge its request is seen low.
  - Mem_snoop_gnt is lowest priority: granted only when no snoop grant is active and Req_snoop == 0; held while Mem_snoop_req is high.
  - At most one of Com_Bus_Gnt_snoop / Mem_snoop_gnt is high.
- Hold counter: increments each OWN cycle; width $clog2(MAX_HOLD+1); saturates; unused when MAX_HOLD = 0.

## Timing
- All outputs registered.
- Grant latency: request high before edge N gives grant high after edge N.
- Release: request seen low at edge N gives grant low after edge N. The next proc grant is issued no earlier than edge N+1, giving a minimum one-cycle idle gap between owners.
- Snoop hand-off: one idle cycle between consecutive snoop/mem grants.
- Simultaneous requests in IDLE: one grant only, chosen by rotating priority; losers keep requesting.
- A request asserted and dropped between edges is never granted.
- Forced release: grant low and arb_timeout high after the same edge; arb_timeout low after the next edge.
- Reset asserted mid-transaction: outputs go to reset values without waiting for clk.

## Test plan
- Reset: rst_n low mid-OWN with Gnt_proc = 8'h04 -> all grants 0, owner_id 0 immediately, before the next clk edge.
- Fairness, NUM_PROC = 8: Req_proc = 8'hFF held, each owner drops its request 3 cycles after grant, then reasserts -> grant order 0,1,...,7,0; one idle cycle between owners.
- Simultaneous: Req_proc = 8'h81 from reset -> index 0 granted first; after release, index 7 granted, not 0.
- Snoop priority: proc 2 owns; Req_snoop = 4'b1010 and Mem_snoop_req = 1 together -> snoop 1, then snoop 3, then Mem_snoop_gnt, with one gap cycle each.
- Timeout, MAX_HOLD = 4: proc 5 holds its request -> grant high for exactly 4 cycles, arb_timeout pulses once; with Req_proc = 8'h21 pending, the next grant goes to 0.
- IDLE isolation: Req_proc = 0, Req_snoop = 4'hF, Mem_snoop_req = 1 -> no snoop or mem grant ever asserted.
